// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit holding the
// architectural HI/LO registers. MULT/MULTU/DIV/DIVU take WIDTH+2 cycles
// from the cycle start is presented to the cycle done is visible.
// MTHI/MTLO write HI/LO directly while the unit is idle. stall holds
// MFHI/MFLO in decode while an operation is in flight.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_write,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] write_value,
    input  logic             read_req,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg_a;
    logic               neg_b;
    logic               is_div;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    // Only the signedness of op matters beyond accept, and it is folded
    // into neg_a/neg_b there; is_div is all of op that RUN/FINISH need.
    logic               op_signed;
    logic [WIDTH-1:0]   in_mag_a;
    logic [WIDTH-1:0]   in_mag_b;
    logic               in_neg_a;
    logic               in_neg_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [2*WIDTH-1:0] acc_next;

    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic [WIDTH-1:0]   hi_fin;
    logic [WIDTH-1:0]   lo_fin;

    assign busy  = (state != S_IDLE);
    assign stall = read_req && busy;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

    // Operand magnitudes and signs as they will be captured on accept.
    always_comb begin
        op_signed = ~op[0];
        in_neg_a  = op_signed && operand_a[WIDTH-1];
        in_neg_b  = op_signed && operand_b[WIDTH-1];
        in_mag_a  = in_neg_a ? (~operand_a + 1'b1) : operand_a;
        in_mag_b  = in_neg_b ? (~operand_b + 1'b1) : operand_b;
    end

    // One iteration: shift-add for multiply, restoring step for divide.
    // Multiply adds into the upper half and shifts right, so after WIDTH
    // steps acc holds the full product. Divide keeps the partial remainder
    // in the upper half and shifts quotient bits into the lower half,
    // pulling dividend bits MSB-first from the captured magnitude.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (mag_b[count] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
        div_shift = {acc[2*WIDTH-1:WIDTH], mag_a[LAST - count]};
        div_ge    = (div_shift >= {1'b0, mag_b});
        if (is_div) begin
            if (div_ge) begin
                acc_next = {div_shift[WIDTH-1:0] - mag_b, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Sign correction of the unsigned magnitude result. With a zero
    // divisor the remainder path ends up holding the dividend magnitude,
    // so restoring the dividend sign reproduces the raw dividend for hi;
    // lo is forced to all ones. Most-negative / -1 needs no special case.
    always_comb begin
        product   = (neg_a ^ neg_b) ? (~acc + 1'b1) : acc;
        quotient  = (neg_a ^ neg_b) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        remainder = neg_a ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
        if (!is_div) begin
            hi_fin = product[2*WIDTH-1:WIDTH];
            lo_fin = product[WIDTH-1:0];
        end else if (mag_b == '0) begin
            hi_fin = remainder;
            lo_fin = '1;
        end else begin
            hi_fin = remainder;
            lo_fin = quotient;
        end
    end

    // Control FSM, operand capture, iteration and HI/LO update.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            count  <= '0;
            acc    <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            is_div <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        mag_a  <= in_mag_a;
                        mag_b  <= in_mag_b;
                        neg_a  <= in_neg_a;
                        neg_b  <= in_neg_b;
                        count  <= '0;
                        acc    <= '0;
                        state  <= S_RUN;
                    end else begin
                        if (hi_write) begin
                            hi_q <= write_value;
                        end
                        if (lo_write) begin
                            lo_q <= write_value;
                        end
                    end
                end
                S_RUN: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    hi_q   <= hi_fin;
                    lo_q   <= lo_fin;
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for the 32-bit unit plus hand-written
// sequences for back-to-back issue, ignored requests mid-run, MTHI/MTLO,
// reset mid-operation and an 8-bit instance.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset;

    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        hi_write;
    logic        lo_write;
    logic [31:0] write_value;
    logic        read_req;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  operand_a8;
    logic [7:0]  operand_b8;
    logic        hi_write8;
    logic        lo_write8;
    logic [7:0]  write_value8;
    logic        read_req8;
    logic        busy8;
    logic        done8;
    logic        stall8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    muldiv_unit #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .hi_write    (hi_write),
        .lo_write    (lo_write),
        .write_value (write_value),
        .read_req    (read_req),
        .busy        (busy),
        .done        (done),
        .stall       (stall),
        .hi          (hi),
        .lo          (lo)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clock       (clock),
        .reset       (reset),
        .start       (start8),
        .op          (op8),
        .operand_a   (operand_a8),
        .operand_b   (operand_b8),
        .hi_write    (hi_write8),
        .lo_write    (lo_write8),
        .write_value (write_value8),
        .read_req    (read_req8),
        .busy        (busy8),
        .done        (done8),
        .stall       (stall8),
        .hi          (hi8),
        .lo          (lo8)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Wait (bounded) until done is seen; n counts the edges waited.
    task automatic waitDone(output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Presents start for one cycle, scrambles the operands after accept,
    // and returns the number of edges from the edge start was presented
    // at until done is visible, plus the number of cycles busy was seen.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, output int lat,
                                 output int busy_cycles);
        op          = o;
        operand_a   = a;
        operand_b   = b;
        start       = 1'b1;
        busy_cycles = 0;
        tick();
        start     = 1'b0;
        op        = OP_MULTU;
        operand_a = 32'hDEADBEEF;
        operand_b = 32'h0BADF00D;
        lat       = 1;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) busy_cycles++;
            tick();
            lat++;
        end
    endtask

    task automatic applyStimulus8(input logic [1:0] o, input logic [7:0] a,
                                  input logic [7:0] b, output int lat,
                                  output int busy_cycles);
        op8         = o;
        operand_a8  = a;
        operand_b8  = b;
        start8      = 1'b1;
        busy_cycles = 0;
        tick();
        start8     = 1'b0;
        operand_a8 = 8'h5A;
        operand_b8 = 8'hA5;
        lat        = 1;
        while (done8 !== 1'b1 && lat < 200) begin
            if (busy8 === 1'b1) busy_cycles++;
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bc;
        int n;
        int stall_errors;
        int done_count;

        vecs[0]  = '{"multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"mult_m3x5",  OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{"div_m7d2",   OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu_10d0",  OP_DIVU,  32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF};
        vecs[4]  = '{"div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{"divu_100d7", OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[6]  = '{"div_7dm2",   OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{"mult_minsq", OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8]  = '{"div_m5d0",   OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[9]  = '{"mult_maxm1", OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
        vecs[10] = '{"multu_2p32", OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[11] = '{"divu_maxd2", OP_DIVU,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h7FFFFFFF};

        reset = 1'b1;
        start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
        hi_write = 1'b0; lo_write = 1'b0; write_value = '0; read_req = 1'b1;
        start8 = 1'b0; op8 = 2'b00; operand_a8 = '0; operand_b8 = '0;
        hi_write8 = 1'b0; lo_write8 = 1'b0; write_value8 = '0; read_req8 = 1'b0;
        repeat (3) tick();

        checkOutput("reset_busy",  64'(busy),  64'd0);
        checkOutput("reset_done",  64'(done),  64'd0);
        checkOutput("reset_stall", 64'(stall), 64'd0);
        checkOutput("reset_hi",    64'(hi),    64'd0);
        checkOutput("reset_lo",    64'(lo),    64'd0);
        checkOutput("reset_hi8",   64'(hi8),   64'd0);
        reset    = 1'b0;
        read_req = 1'b0;
        tick();

        // Table-driven vectors.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
            checkOutput({vecs[i].name, "_hi"},      64'(hi),   64'(vecs[i].exp_hi));
            checkOutput({vecs[i].name, "_lo"},      64'(lo),   64'(vecs[i].exp_lo));
            checkOutput({vecs[i].name, "_latency"}, 64'(lat),  64'd34);
            checkOutput({vecs[i].name, "_busy"},    64'(bc),   64'd33);
            tick();
            checkOutput({vecs[i].name, "_done_1cy"}, 64'(done), 64'd0);
        end

        // Back-to-back: second start presented while done is high.
        applyStimulus(OP_MULTU, 32'd3, 32'd4, lat, bc);
        checkOutput("b2b_first_lo", 64'(lo), 64'd12);
        applyStimulus(OP_MULTU, 32'd5, 32'd6, lat, bc);
        checkOutput("b2b_second_lo",  64'(lo),  64'd30);
        checkOutput("b2b_second_lat", 64'(lat), 64'd34);
        tick();

        // MULTU 6x7 with ignored start/MTLO mid-run and MFHI/MFLO stalled.
        op = OP_MULTU; operand_a = 32'd6; operand_b = 32'd7; start = 1'b1;
        tick();
        start    = 1'b0;
        read_req = 1'b1;
        repeat (4) tick();
        start = 1'b1; op = OP_DIVU; operand_a = 32'd100; operand_b = 32'd3;
        lo_write = 1'b1; write_value = 32'h55;
        tick();
        start    = 1'b0;
        lo_write = 1'b0;
        checkOutput("midrun_busy", 64'(busy), 64'd1);
        stall_errors = 0;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            if (stall !== 1'b1) stall_errors++;
            tick();
            n++;
        end
        checkOutput("midrun_done_seen", 64'(done),         64'd1);
        checkOutput("midrun_stall",     64'(stall_errors), 64'd0);
        checkOutput("midrun_stall_end", 64'(stall),        64'd0);
        checkOutput("midrun_hi",        64'(hi),           64'd0);
        checkOutput("midrun_lo",        64'(lo),           64'd42);
        read_req = 1'b0;
        tick();
        checkOutput("midrun_no_second", 64'(busy), 64'd0);

        // MTHI / MTLO while idle.
        hi_write = 1'b1; write_value = 32'h1234;
        tick();
        hi_write = 1'b0;
        checkOutput("mthi_hi", 64'(hi), 64'h1234);
        checkOutput("mthi_lo", 64'(lo), 64'd42);
        lo_write = 1'b1; write_value = 32'hABCD;
        tick();
        lo_write = 1'b0;
        checkOutput("mtlo_lo", 64'(lo), 64'hABCD);

        // start has priority over MTHI in IDLE.
        op = OP_MULTU; operand_a = 32'd2; operand_b = 32'd3;
        start = 1'b1; hi_write = 1'b1; write_value = 32'h9999;
        tick();
        start = 1'b0; hi_write = 1'b0;
        checkOutput("prio_hi_kept", 64'(hi),   64'h1234);
        checkOutput("prio_busy",    64'(busy), 64'd1);
        waitDone(n);
        checkOutput("prio_hi", 64'(hi), 64'd0);
        checkOutput("prio_lo", 64'(lo), 64'd6);
        tick();

        // Reset during RUN cycle 10.
        hi_write = 1'b1; write_value = 32'h77;
        tick();
        hi_write = 1'b0;
        op = OP_MULTU; operand_a = 32'hFFFFFFFF; operand_b = 32'hFFFFFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        checkOutput("rst_mid_hi",   64'(hi),   64'd0);
        checkOutput("rst_mid_lo",   64'(lo),   64'd0);
        done_count = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) done_count++;
            tick();
        end
        checkOutput("rst_mid_no_done", 64'(done_count), 64'd0);
        checkOutput("rst_mid_hi_after", 64'(hi), 64'd0);

        // WIDTH=8 instance.
        applyStimulus8(OP_MULT, 8'h80, 8'h80, lat, bc);
        checkOutput("w8_mult_hi",  64'(hi8), 64'h40);
        checkOutput("w8_mult_lo",  64'(lo8), 64'h00);
        checkOutput("w8_mult_lat", 64'(lat), 64'd10);
        checkOutput("w8_mult_busy", 64'(bc), 64'd9);
        tick();
        applyStimulus8(OP_DIV, 8'h80, 8'hFF, lat, bc);
        checkOutput("w8_ovf_hi", 64'(hi8), 64'h00);
        checkOutput("w8_ovf_lo", 64'(lo8), 64'h80);
        tick();
        applyStimulus8(OP_DIVU, 8'hC8, 8'h0D, lat, bc);
        checkOutput("w8_divu_hi", 64'(hi8), 64'h05);
        checkOutput("w8_divu_lo", 64'(lo8), 64'h0F);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
